// File: rtl/copperv_bus_pkg.sv
// Shared bus types for the copperv core: read-owner IDs, arbiter lock states
// and the bus widths used by the core and its memory adapters.
package copperv_bus_pkg;

  localparam int BUS_ADDR_WIDTH = 32;
  localparam int BUS_DATA_WIDTH = 32;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_t;

  typedef enum logic {
    ARB_OPEN = 1'b0,
    ARB_HELD = 1'b1
  } arb_state_t;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWNER_INST) ? OWNER_DATA : OWNER_INST;
  endfunction

endpackage

// File: rtl/copperv_read_arbiter_if.sv
// One read channel: valid/ready address request plus valid/ready response.
// The master issues addresses and accepts responses; the slave serves them.
interface copperv_read_arbiter_if
  import copperv_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH = BUS_DATA_WIDTH
);
  logic                  raddr_valid;
  logic                  raddr_ready;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  rdata_valid;
  logic                  rdata_ready;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output raddr_valid, raddr, rdata_ready,
    input  raddr_ready, rdata_valid, rdata
  );

  modport slave (
    input  raddr_valid, raddr, rdata_ready,
    output raddr_ready, rdata_valid, rdata
  );
endinterface

// File: rtl/copperv_owner_fifo.sv
// In-order FIFO of read owners; the head names the channel that owns the next
// memory response. DEPTH must be a power of two so the pointers wrap naturally.
module copperv_owner_fifo
  import copperv_bus_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  owner_t           push_owner,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output owner_t           head
);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  owner_t           mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_owner;
  end

endmodule

// File: rtl/copperv_read_arbiter.sv
// Shares one memory read port between instruction fetch and data load:
// combinational address arbitration with stall lock, in-order response routing.
module copperv_read_arbiter
  import copperv_bus_pkg::*;
#(
  parameter  int ADDR_WIDTH      = BUS_ADDR_WIDTH,
  parameter  int DATA_WIDTH      = BUS_DATA_WIDTH,
  parameter  int MAX_OUTSTANDING = 4,
  parameter  int DATA_PRIORITY   = 0,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  copperv_read_arbiter_if.slave  i_bus,
  copperv_read_arbiter_if.slave  d_bus,
  copperv_read_arbiter_if.master m_bus,
  output logic [CNT_W-1:0]       outstanding,
  output logic                   spurious_resp
);

  arb_state_t            state_reg, state_next;
  owner_t                held_reg, held_next;
  owner_t                rr_reg, rr_next;
  logic                  spurious_reg, spurious_next;

  owner_t                grant;
  logic                  grant_req;
  logic                  fifo_full;
  logic                  fifo_empty;
  owner_t                head;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [DATA_WIDTH-1:0] resp_data;

  always_comb begin
    grant = OWNER_INST;
    if (state_reg == ARB_HELD) begin
      grant = held_reg;
    end else if (i_bus.raddr_valid && d_bus.raddr_valid) begin
      // rr_reg names the channel favoured on the next conflict
      grant = (DATA_PRIORITY != 0) ? OWNER_DATA : rr_reg;
    end else if (d_bus.raddr_valid) begin
      grant = OWNER_DATA;
    end
  end

  assign grant_req = (grant == OWNER_DATA) ? d_bus.raddr_valid : i_bus.raddr_valid;
  assign addr_sel  = (grant == OWNER_DATA) ? d_bus.raddr : i_bus.raddr;

  assign m_bus.raddr_valid = grant_req && !fifo_full;
  assign m_bus.raddr       = addr_sel;
  assign i_bus.raddr_ready = m_bus.raddr_valid && (grant == OWNER_INST) && m_bus.raddr_ready;
  assign d_bus.raddr_ready = m_bus.raddr_valid && (grant == OWNER_DATA) && m_bus.raddr_ready;
  assign push              = m_bus.raddr_valid && m_bus.raddr_ready;

  always_comb begin
    state_next = state_reg;
    held_next  = held_reg;
    rr_next    = rr_reg;
    if (push) rr_next = other_owner(grant);
    case (state_reg)
      ARB_OPEN: begin
        if (m_bus.raddr_valid && !m_bus.raddr_ready) begin
          state_next = ARB_HELD;
          held_next  = grant;
        end
      end
      ARB_HELD: begin
        if (push || !m_bus.raddr_valid) state_next = ARB_OPEN;
      end
      default: state_next = ARB_OPEN;
    endcase
  end

  // With nothing outstanding, any response is swallowed and flagged.
  assign resp_data         = m_bus.rdata;
  assign i_bus.rdata       = resp_data;
  assign d_bus.rdata       = resp_data;
  assign i_bus.rdata_valid = !fifo_empty && (head == OWNER_INST) && m_bus.rdata_valid;
  assign d_bus.rdata_valid = !fifo_empty && (head == OWNER_DATA) && m_bus.rdata_valid;
  assign m_bus.rdata_ready = fifo_empty ? m_bus.rdata_valid
                           : ((head == OWNER_DATA) ? d_bus.rdata_ready : i_bus.rdata_ready);
  assign pop               = !fifo_empty && m_bus.rdata_valid && m_bus.rdata_ready;
  assign spurious_next     = fifo_empty && m_bus.rdata_valid;
  assign spurious_resp     = spurious_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ARB_OPEN;
      held_reg     <= OWNER_INST;
      rr_reg       <= OWNER_DATA;
      spurious_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      held_reg     <= held_next;
      rr_reg       <= rr_next;
      spurious_reg <= spurious_next;
    end
  end

  copperv_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_owner (grant),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (outstanding),
    .head       (head)
  );

endmodule

// File: tb/tb_copperv_read_arbiter.sv
// Randomized and directed bench for copperv_read_arbiter against a queue-based
// reference model of ownership, grant rules and response routing.
module tb_copperv_read_arbiter;
  import copperv_bus_pkg::*;

  localparam int MAXO = 4;

  logic       clk;
  logic       rst;
  logic [2:0] outstanding;
  logic       spurious_resp;

  copperv_read_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) i_bus ();
  copperv_read_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) d_bus ();
  copperv_read_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_bus ();

  copperv_read_arbiter #(
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .MAX_OUTSTANDING (MAXO),
    .DATA_PRIORITY   (0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_bus         (i_bus),
    .d_bus         (d_bus),
    .m_bus         (m_bus),
    .outstanding   (outstanding),
    .spurious_resp (spurious_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of owners (0 = inst, 1 = data) in issue order.
  bit q[$];
  bit held;
  bit held_owner;
  bit rr_pref;
  bit spur_exp;
  bit acc_i;
  bit acc_d;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    held     = 1'b0;
    held_owner = 1'b0;
    rr_pref  = 1'b1;
    spur_exp = 1'b0;
  endtask

  task automatic cycle(input logic iv, input logic [31:0] ia, input logic dv, input logic [31:0] da,
                       input logic mr, input logic mv, input logic [31:0] md,
                       input logic ir, input logic dr);
    int        n;
    bit        g, gv, full, em_v, e_ir, e_dr, e_irv, e_drv, e_mrr, h, pop;
    logic [31:0] em_a;
    i_bus.raddr_valid = iv;  i_bus.raddr = ia;  i_bus.rdata_ready = ir;
    d_bus.raddr_valid = dv;  d_bus.raddr = da;  d_bus.rdata_ready = dr;
    m_bus.raddr_ready = mr;  m_bus.rdata_valid = mv;  m_bus.rdata = md;
    @(negedge clk);
    n    = q.size();
    full = (n >= MAXO);
    if (held)          g = held_owner;
    else if (iv && dv) g = rr_pref;
    else               g = dv;
    gv   = g ? dv : iv;
    em_v = gv && !full;
    em_a = g ? da : ia;
    e_ir = em_v && !g && mr;
    e_dr = em_v && g && mr;
    h    = 1'b0;
    if (n == 0) begin
      e_mrr = mv;  e_irv = 1'b0;  e_drv = 1'b0;
    end else begin
      h     = q[0];
      e_irv = mv && !h;
      e_drv = mv && h;
      e_mrr = h ? dr : ir;
    end
    check("m_raddr_valid", 64'(m_bus.raddr_valid), 64'(em_v));
    if (em_v) check("m_raddr", 64'(m_bus.raddr), 64'(em_a));
    check("i_raddr_ready", 64'(i_bus.raddr_ready), 64'(e_ir));
    check("d_raddr_ready", 64'(d_bus.raddr_ready), 64'(e_dr));
    check("i_rdata_valid", 64'(i_bus.rdata_valid), 64'(e_irv));
    check("d_rdata_valid", 64'(d_bus.rdata_valid), 64'(e_drv));
    check("m_rdata_ready", 64'(m_bus.rdata_ready), 64'(e_mrr));
    check("outstanding", 64'(outstanding), 64'(n));
    check("spurious_resp", 64'(spurious_resp), 64'(spur_exp));
    if (e_irv) check("i_rdata", 64'(i_bus.rdata), 64'(md));
    if (e_drv) check("d_rdata", 64'(d_bus.rdata), 64'(md));
    pop = (n > 0) && mv && e_mrr;
    if (pop) begin
      void'(q.pop_front());
      $display("resp %s data=%08h", h ? "data" : "inst", md);
    end
    if (mv && n == 0) $display("resp dropped data=%08h", md);
    if (em_v && mr) begin
      q.push_back(g);
      rr_pref = !g;
      $display("req  %s addr=%08h", g ? "data" : "inst", em_a);
    end
    held       = em_v && !mr;
    held_owner = g;
    spur_exp   = (n == 0) && mv;
    acc_i      = e_ir;
    acc_d      = e_dr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() > 0; k++)
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, $urandom, 1'b1, 1'b1);
    check("drain_done", 64'(outstanding), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        iv, dv, i_pend, d_pend;
    logic [31:0] ia, da;

    rst = 1'b0;
    i_bus.raddr_valid = 1'b0; i_bus.raddr = '0; i_bus.rdata_ready = 1'b0;
    d_bus.raddr_valid = 1'b0; d_bus.raddr = '0; d_bus.rdata_ready = 1'b0;
    m_bus.raddr_ready = 1'b0; m_bus.rdata_valid = 1'b0; m_bus.rdata = '0;
    #3;
    check("rst_outstanding", 64'(outstanding), 64'd0);
    check("rst_spurious", 64'(spurious_resp), 64'd0);
    check("rst_m_raddr_valid", 64'(m_bus.raddr_valid), 64'd0);
    check("rst_m_rdata_ready", 64'(m_bus.rdata_ready), 64'd0);
    check("rst_i_rdata_valid", 64'(i_bus.rdata_valid), 64'd0);
    check("rst_d_rdata_valid", 64'(d_bus.rdata_valid), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    model_reset();

    // Single fetch, response two cycles later
    cycle(1'b1, 32'h0000_0100, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    idle_cycle();
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    idle_cycle();

    // Round-robin conflict with responses streaming back
    for (int k = 0; k < 8; k++)
      cycle(1'b1, 32'h200, 1'b1, 32'h8000, 1'b1, 1'(k > 0), $urandom, 1'b1, 1'b1);
    drain();

    // Stall lock: data arrives while inst is stalled
    cycle(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b1, 32'h300, 1'b1, 32'h9000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b1, 32'h300, 1'b1, 32'h9000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b1, 32'h300, 1'b1, 32'h9000, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 32'h9000, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    drain();

    // Full: four accepted, fifth blocked until the cycle after a pop
    for (int k = 0; k < 4; k++)
      cycle(1'b0, 32'h0, 1'b1, 32'h1000 + 32'(k * 4), 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    check("full_outstanding", 64'(outstanding), 64'd4);
    cycle(1'b0, 32'h0, 1'b1, 32'h1010, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 32'h1010, 1'b1, 1'b1, 32'h1111_2222, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 32'h1010, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    check("full_resumed", 64'(outstanding), 64'd4);
    drain();

    // Data response backpressure
    cycle(1'b0, 32'h0, 1'b1, 32'h4000, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFE_0001, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFE_0001, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFE_0001, 1'b1, 1'b1);
    idle_cycle();

    // Spurious response on an empty FIFO
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h5151_5151, 1'b0, 1'b0);
    idle_cycle();
    idle_cycle();

    // Asynchronous reset with two outstanding
    cycle(1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 32'h600, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    check("pre_rst_outstanding", 64'(outstanding), 64'(q.size()));
    i_bus.raddr_valid = 1'b0; d_bus.raddr_valid = 1'b0;
    m_bus.raddr_ready = 1'b0; m_bus.rdata_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_outstanding", 64'(outstanding), 64'd0);
    check("async_rst_spurious", 64'(spurious_resp), 64'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h7777_0000, 1'b1, 1'b1);
    idle_cycle();
    idle_cycle();

    // Randomized traffic; pending requests hold valid and address until accepted
    i_pend = 1'b0; d_pend = 1'b0; ia = '0; da = '0; iv = 1'b0; dv = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (!i_pend) begin
        iv = 1'($urandom_range(0, 1));
        ia = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_pend) begin
        dv = 1'($urandom_range(0, 1));
        da = $urandom & 32'hFFFF_FFFC;
      end
      cycle(iv, ia, dv, da, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom,
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
      i_pend = iv && !acc_i;
      d_pend = dv && !acc_d;
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
